// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with programmable almost-full/empty levels,
// occupancy count, standard or first-word-fall-through read, flush and sticky errors.
module sync_fifo_flex #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AF_LEVEL   = 3,
    parameter int unsigned AE_LEVEL   = 1,
    parameter int unsigned FWFT       = 0,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_push,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_full,
    output logic                  w_almost_full,
    input  logic                  r_pop,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [CW-1:0]         count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full_c, empty_c;
    logic                  wr_en_c, rd_en_c;

    // All flags come from the registered occupancy only.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == CW'(0));
    assign wr_en_c = w_push & ~full_c;
    assign rd_en_c = r_pop & ~empty_c;

    assign w_full         = full_c;
    assign r_empty        = empty_c;
    assign w_almost_full  = (count_q >= CW'(AF_LEVEL));
    assign r_almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count          = count_q;
    assign overflow       = ovf_q;
    assign underflow      = udf_q;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en_c, rd_en_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error event in the same cycle beats the clear.
        if (clr_err)          ovf_d = 1'b0;
        if (w_push && full_c) ovf_d = 1'b1;
        if (clr_err)          udf_d = 1'b0;
        if (r_pop && empty_c) udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c && !flush) mem_q[wr_ptr_q] <= w_data;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;

            // Registered read: data appears the cycle after an accepted pop, else holds.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_en_c && !flush) begin
                    rdata_q <= mem_q[rd_ptr_q];
                end
            end
            assign r_data = rdata_q;
        end else begin : g_fwft
            assign r_data = empty_c ? '0 : mem_q[rd_ptr_q];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench for sync_fifo_flex: standard-read and FWFT instances side by side.
module tb_sync_fifo_flex;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush0, push0, pop0, clr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          full0, afull0, empty0, aempty0, ovf0, udf0;
    logic [CW-1:0] count0;
    logic          flush1, push1, pop1, clr1;
    logic [DW-1:0] wdata1, rdata1;
    logic          full1, afull1, empty1, aempty1, ovf1, udf1;
    logic [CW-1:0] count1;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    logic          pend = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .w_push(push0), .w_data(wdata0),
        .w_full(full0), .w_almost_full(afull0), .r_pop(pop0), .r_data(rdata0),
        .r_empty(empty0), .r_almost_empty(aempty0), .count(count0), .clr_err(clr0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .w_push(push1), .w_data(wdata1),
        .w_full(full1), .w_almost_full(afull1), .r_pop(pop1), .r_data(rdata1),
        .r_empty(empty1), .r_almost_empty(aempty1), .count(count1), .clr_err(clr1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        flush0 = 1'b0; push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; wdata0 = '0;
    endtask

    task automatic push_d0(input logic [DW-1:0] d);
        push0 = 1'b1; wdata0 = d;
        tick();
        idle0();
    endtask

    task automatic pop_d0(input logic [DW-1:0] exp);
        exp_q.push_back(exp);
        pop0 = 1'b1;
        tick();
        idle0();
    endtask

    // Monitor: a pop seen accepted at one negedge is checked at the next one.
    always @(negedge clk) begin
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected actual=%h required=none", rdata0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rdata0 !== e) begin
                    errors++;
                    $display("FAIL rd_data actual=%h required=%h", rdata0, e);
                end
            end
        end
        pend = rst_n && pop0 && !empty0 && !flush0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle0();
        flush1 = 1'b0; push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; wdata1 = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_udf", 32'(udf0), 32'd0);
        chk("rst_aempty", 32'(aempty0), 32'd1);
        chk("rst_afull", 32'(afull0), 32'd0);
        chk("rst1_empty", 32'(empty1), 32'd1);
        chk("rst1_rdata", rdata1, 32'd0);

        // Fill to full, checking thresholds at each level
        for (int i = 0; i < 4; i++) begin
            push_d0(32'hA0 + 32'(i));
            chk("fill_count", 32'(count0), 32'(i + 1));
            chk("fill_afull", 32'(afull0), (i + 1 >= 3) ? 32'd1 : 32'd0);
            chk("fill_aempty", 32'(aempty0), (i + 1 <= 1) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(full0), (i == 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) pop_d0(32'hA0 + 32'(i));
        tick();
        chk("drain_empty", 32'(empty0), 32'd1);
        chk("drain_count", 32'(count0), 32'd0);

        // Full with simultaneous push and pop: push dropped, overflow set
        for (int i = 0; i < 4; i++) push_d0(32'hA0 + 32'(i));
        exp_q.push_back(32'hA0);
        push0 = 1'b1; wdata0 = 32'hFF; pop0 = 1'b1;
        tick();
        idle0();
        chk("fullpp_count", 32'(count0), 32'd3);
        chk("fullpp_ovf", 32'(ovf0), 32'd1);
        clr0 = 1'b1;
        tick();
        idle0();
        chk("clr_ovf", 32'(ovf0), 32'd0);
        pop_d0(32'hA1);
        pop_d0(32'hA2);
        pop_d0(32'hA3);
        tick();
        chk("fullpp_empty", 32'(empty0), 32'd1);

        // Interleaved push/pop at count 2 across pointer wrap
        push_d0(32'h00);
        push_d0(32'h01);
        for (int i = 2; i < 10; i++) begin
            exp_q.push_back(32'(i - 2));
            push0 = 1'b1; wdata0 = 32'(i); pop0 = 1'b1;
            tick();
            idle0();
            chk("wrap_count", 32'(count0), 32'd2);
        end
        pop_d0(32'h08);
        pop_d0(32'h09);
        tick();
        chk("wrap_empty", 32'(empty0), 32'd1);

        // Pop while empty sets underflow, read data holds
        pop0 = 1'b1;
        tick();
        idle0();
        chk("udf_set", 32'(udf0), 32'd1);
        chk("udf_count", 32'(count0), 32'd0);
        chk("udf_rdata_hold", rdata0, 32'h09);

        // Flush with count 3 plus push
        push_d0(32'h31);
        push_d0(32'h32);
        push_d0(32'h33);
        chk("preflush_count", 32'(count0), 32'd3);
        flush0 = 1'b1; push0 = 1'b1; wdata0 = 32'h34;
        tick();
        idle0();
        chk("flush_count", 32'(count0), 32'd0);
        chk("flush_empty", 32'(empty0), 32'd1);
        chk("flush_rdata_hold", rdata0, 32'h09);
        chk("flush_udf_kept", 32'(udf0), 32'd1);

        // Set beats clear in the same cycle
        clr0 = 1'b1; pop0 = 1'b1;
        tick();
        idle0();
        chk("setwins_udf", 32'(udf0), 32'd1);
        clr0 = 1'b1;
        tick();
        idle0();
        chk("clr_udf", 32'(udf0), 32'd0);

        // FWFT: head visible the cycle after push, no pop needed
        push1 = 1'b1; wdata1 = 32'h55;
        tick();
        push1 = 1'b0;
        chk("fwft_empty", 32'(empty1), 32'd0);
        chk("fwft_head", rdata1, 32'h55);
        tick();
        chk("fwft_hold", rdata1, 32'h55);
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        chk("fwft_pop_rdata", rdata1, 32'd0);
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        push1 = 1'b1; wdata1 = 32'h11;
        tick();
        wdata1 = 32'h22;
        tick();
        push1 = 1'b0;
        chk("fwft_head2", rdata1, 32'h11);
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        chk("fwft_next", rdata1, 32'h22);
        chk("fwft_count", 32'(count1), 32'd1);

        tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
